// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one 32:1 register read mux among NUM_REQ requesters.
// Latency: grant edge -> select settles -> capture edge; ack/rdata visible one cycle, one read per 3 cycles.
// Backpressure: requests are level-held until ack; only the IDLE state samples req, others wait.
module regfile_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [ADDR_WIDTH-1:0]         mux_select,
    input  logic [DATA_WIDTH-1:0]         mux_out,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SELECT = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]            state;
    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         grant;
    logic [PW-1:0]         winner;
    logic [PW-1:0]         next_ptr;
    logic                  found;
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign addr_arr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // First set request at or above rr_ptr, wrapping past the top requester.
    always_comb begin
        int            idx;
        logic [PW-1:0] cand;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = PW'(idx);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign next_ptr = (int'(winner) == NUM_REQ - 1) ? '0 : winner + PW'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            mux_select <= '0;
            rdata      <= '0;
            ack        <= '0;
            rr_ptr     <= '0;
            grant      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        mux_select <= addr_arr[winner];
                        grant      <= winner;
                        rr_ptr     <= next_ptr;
                        state      <= SELECT;
                    end
                end
                SELECT: begin
                    rdata <= mux_out;
                    ack   <= NUM_REQ'(1) << grant;
                    state <= RESP;
                end
                RESP: begin
                    ack   <= '0;
                    state <= IDLE;
                end
                default: begin
                    ack   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: transaction-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_regfile_read_arbiter;

    localparam int NUM_REQ = 4;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [19:0] req_addr;
    logic [4:0]  mux_select;
    logic [31:0] mux_out;
    logic [31:0] rdata;
    logic [3:0]  ack;
    logic        busy;

    logic [31:0] regs [32];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    regfile_read_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .req(req), .req_addr(req_addr),
        .mux_select(mux_select), .mux_out(mux_out), .rdata(rdata),
        .ack(ack), .busy(busy)
    );

    assign mux_out = regs[mux_select];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Reference model: one transaction = grant cycle, select cycle, ack cycle.
    int          m_phase = 0;
    int          m_ptr = 0;
    int          m_grant = 0;
    logic [4:0]  m_sel = '0;
    logic [31:0] m_rdata = '0;
    logic [3:0]  m_ack = '0;

    function automatic int pick(input logic [3:0] r, input int p);
        logic [3:0] rot;
        for (int k = 0; k < NUM_REQ; k++) begin
            rot = r >> ((p + k) % NUM_REQ);
            if (rot[0]) return (p + k) % NUM_REQ;
        end
        return 0;
    endfunction

    function automatic logic [4:0] addr_of(input logic [19:0] a, input int w);
        logic [19:0] t;
        t = a >> (w * 5);
        return t[4:0];
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_phase <= 0;
            m_ptr   <= 0;
            m_grant <= 0;
            m_sel   <= '0;
            m_rdata <= '0;
            m_ack   <= '0;
        end else if (m_phase == 0) begin
            if (req != 4'b0000) begin
                m_grant <= pick(req, m_ptr);
                m_sel   <= addr_of(req_addr, pick(req, m_ptr));
                m_ptr   <= (pick(req, m_ptr) + 1) % NUM_REQ;
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            m_rdata <= regs[m_sel];
            m_ack   <= 4'b0001 << m_grant;
            m_phase <= 2;
        end else begin
            m_ack   <= '0;
            m_phase <= 0;
        end
    end

    always @(negedge clock) begin
        checks = checks + 5;
        if (mux_select !== m_sel) begin
            errors = errors + 1;
            $display("FAIL cmp_mux_select t=%0t got %0d expected %0d", $time, mux_select, m_sel);
        end
        if (rdata !== m_rdata) begin
            errors = errors + 1;
            $display("FAIL cmp_rdata t=%0t got %h expected %h", $time, rdata, m_rdata);
        end
        if (ack !== m_ack) begin
            errors = errors + 1;
            $display("FAIL cmp_ack t=%0t got %b expected %b", $time, ack, m_ack);
        end
        if (busy !== (m_phase != 0)) begin
            errors = errors + 1;
            $display("FAIL cmp_busy t=%0t got %b expected %b", $time, busy, (m_phase != 0));
        end
        if ($countones(ack) > 1) begin
            errors = errors + 1;
            $display("FAIL cmp_onehot t=%0t got %b expected at most one bit", $time, ack);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        tick(1);
        reset = 1'b0;
        req   = '0;
        #1;
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sel", {27'd0, mux_select}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        tick(1);
        reset = 1'b1;
    endtask

    task automatic set_addr(input int r, input logic [4:0] a);
        req_addr[r*5 +: 5] = a;
    endtask

    // Returns at +2 inside the first cycle showing an ack; times out as a failure.
    task automatic wait_ack(input string nm, output logic [3:0] a, output logic [31:0] d,
                            output int c);
        a = '0; d = '0; c = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (ack != 4'b0000) begin
                a = ack; d = rdata; c = cyc;
                return;
            end
        end
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s timeout got no ack expected ack within 20 cycles", nm);
    endtask

    task automatic single_read(input string nm, input int r, input logic [4:0] a,
                               input logic [31:0] expd);
        logic [3:0]  ga;
        logic [31:0] gd;
        int          gc;
        set_addr(r, a);
        req[r] = 1'b1;
        wait_ack(nm, ga, gd, gc);
        chk({nm, "_ack"}, {28'd0, ga}, {28'd0, 4'b0001 << r});
        chk({nm, "_rdata"}, gd, expd);
        chk({nm, "_sel"}, {27'd0, mux_select}, {27'd0, a});
        req[r] = 1'b0;
        tick(1);
    endtask

    logic [3:0]  order [8];
    int          tcyc  [8];
    logic [3:0]  ga;
    logic [31:0] gd;
    int          gc;
    logic [3:0]  pend;
    int          cnt;

    initial begin
        #100000;
        $display("FAIL watchdog got no finish expected finish before 100us");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'hCAFE_0000 | i;
        regs[5] = 32'hDEAD_BEEF;
        regs[0] = 32'h0BAD_F00D;
        req = '0;
        req_addr = '0;
        reset = 1'b1;
        #3 reset = 1'b0;
        tick(2);
        reset = 1'b1;

        // Single requester, literal cycle-by-cycle expectations
        set_addr(0, 5'd5);
        req = 4'b0001;
        tick(1);
        chk("t1_grant_sel", {27'd0, mux_select}, 32'd5);
        chk("t1_grant_busy", {31'd0, busy}, 32'd1);
        chk("t1_grant_ack", {28'd0, ack}, 32'd0);
        tick(1);
        chk("t1_ack", {28'd0, ack}, 32'd1);
        chk("t1_rdata", rdata, 32'hDEAD_BEEF);
        chk("t1_resp_busy", {31'd0, busy}, 32'd1);
        req = 4'b0000;
        tick(1);
        chk("t1_idle_ack", {28'd0, ack}, 32'd0);
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);
        chk("t1_hold_rdata", rdata, 32'hDEAD_BEEF);
        chk("t1_hold_sel", {27'd0, mux_select}, 32'd5);

        // Simultaneous req[1] and req[2]
        do_reset();
        set_addr(1, 5'd3);
        set_addr(2, 5'd31);
        req = 4'b0110;
        wait_ack("t2_first", ga, gd, gc);
        chk("t2_first_ack", {28'd0, ga}, 32'd2);
        chk("t2_first_rdata", gd, 32'hCAFE_0003);
        req = req & ~ga;
        wait_ack("t2_second", ga, gd, gc);
        chk("t2_second_ack", {28'd0, ga}, 32'd4);
        chk("t2_second_rdata", gd, 32'hCAFE_001F);
        req = req & ~ga;
        tick(1);

        // All four held, dropping for one cycle after each ack
        do_reset();
        for (int i = 0; i < 4; i++) set_addr(i, 5'(i + 1));
        req = 4'b1111;
        pend = '0;
        cnt = 0;
        for (int k = 0; k < 60 && cnt < 8; k++) begin
            tick(1);
            req = req | pend;
            pend = '0;
            if (ack != 4'b0000) begin
                order[cnt] = ack;
                tcyc[cnt] = cyc;
                cnt = cnt + 1;
                req = req & ~ack;
                pend = ack;
            end
        end
        chk("t3_count", cnt, 32'd8);
        for (int k = 0; k < cnt; k++) begin
            chk("t3_order", {28'd0, order[k]}, {28'd0, 4'b0001 << (k % 4)});
            if (k >= 1) chk("t3_spacing", tcyc[k] - tcyc[k-1], 32'd3);
            if (k >= 4) chk("t3_same_req", tcyc[k] - tcyc[k-4], 32'd12);
        end
        req = '0;
        tick(3);

        // Boundary indices on requester 3
        do_reset();
        single_read("t4_idx0", 3, 5'd0, 32'h0BAD_F00D);
        single_read("t4_idx31", 3, 5'd31, 32'hCAFE_001F);

        // Late address change after grant
        set_addr(0, 5'd7);
        req = 4'b0001;
        tick(1);
        chk("t5_sel", {27'd0, mux_select}, 32'd7);
        set_addr(0, 5'd9);
        tick(1);
        chk("t5_ack", {28'd0, ack}, 32'd1);
        chk("t5_rdata", rdata, 32'hCAFE_0007);
        req = '0;
        tick(1);

        // Withdrawal after grant
        set_addr(1, 5'd4);
        req = 4'b0010;
        tick(1);
        req = 4'b0000;
        tick(1);
        chk("t5w_ack", {28'd0, ack}, 32'd2);
        chk("t5w_rdata", rdata, 32'hCAFE_0004);
        tick(1);
        chk("t5w_ack_clear", {28'd0, ack}, 32'd0);
        tick(1);
        chk("t5w_idle_busy", {31'd0, busy}, 32'd0);

        // Reset during SELECT, then pointer restart
        do_reset();
        single_read("t6_pre", 0, 5'd2, 32'hCAFE_0002);
        set_addr(1, 5'd6);
        req = 4'b0010;
        tick(1);
        chk("t6_sel_busy", {31'd0, busy}, 32'd1);
        chk("t6_sel_sel", {27'd0, mux_select}, 32'd6);
        reset = 1'b0;
        #1;
        chk("t6_rst_ack", {28'd0, ack}, 32'd0);
        chk("t6_rst_rdata", rdata, 32'd0);
        chk("t6_rst_sel", {27'd0, mux_select}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        tick(1);
        chk("t6_no_ack", {28'd0, ack}, 32'd0);
        set_addr(0, 5'd8);
        set_addr(2, 5'd10);
        req = 4'b0101;
        reset = 1'b1;
        wait_ack("t6_first", ga, gd, gc);
        chk("t6_first_ack", {28'd0, ga}, 32'd1);
        chk("t6_first_rdata", gd, 32'hCAFE_0008);
        req = req & ~ga;
        wait_ack("t6_second", ga, gd, gc);
        chk("t6_second_ack", {28'd0, ga}, 32'd4);
        chk("t6_second_rdata", gd, 32'hCAFE_000A);
        req = '0;
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
